trigger_conditioner: RTL and testbench

- Upstream stage of glitch_control. Conditions the raw asynchronous target trigger pin (ui_in[0]) into a clean, single-cycle trigger strobe.
- Pipeline: metastability synchronizer, then programmable deglitch filter, then edge selection, then an arm / Nth-edge counter.
- Output trigger_o drives glitch_control's trigger_i.

---
 rtl/glitch_pkg.sv | 27 ++
 rtl/trigger_filter.sv | 59 +++++
 rtl/trigger_conditioner.sv | 132 +++++++++++++
 tb/tb_trigger_conditioner.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch_control trigger path: edge-select encodings,
// the conditioner FSM states and the edge-qualification helper.
package glitch_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  // The reserved encoding 2'b11 behaves like rising.
  function automatic logic edge_qualifies(input logic [1:0] sel,
                                          input logic       rise,
                                          input logic       fall);
    logic q;
    case (sel)
      EDGE_FALL: q = fall;
      EDGE_BOTH: q = rise | fall;
      default:   q = rise;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/trigger_filter.sv
// Synchronizes the raw trigger pin and deglitches it: a new level is accepted only
// after it has been seen flen+1 consecutive cycles, producing one-cycle edge events.
module trigger_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                trigger_i,
  input  logic [FILTER_W-1:0] flen,
  output logic                filt,
  output logic                rise_evt,
  output logic                fall_evt
);

  logic [SYNC_STAGES-1:0] sync_chain_r;
  logic [FILTER_W-1:0]    cnt_r;
  logic                   filt_r;
  logic                   sync_s;
  logic                   differ_s;
  logic                   settle_s;

  // Metastability chain; the oldest stage feeds the filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_chain_r <= '0;
    end else begin
      sync_chain_r <= {sync_chain_r[SYNC_STAGES-2:0], trigger_i};
    end
  end

  assign sync_s = sync_chain_r[SYNC_STAGES-1];

  // A counter left above a newly latched shorter flen still settles.
  always_comb begin
    differ_s = (sync_s != filt_r);
    settle_s = differ_s && (cnt_r >= flen);
  end

  // Stability counter and accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      filt_r <= 1'b0;
    end else if (settle_s) begin
      cnt_r  <= '0;
      filt_r <= sync_s;
    end else if (differ_s) begin
      cnt_r  <= cnt_r + {{(FILTER_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r  <= '0;
    end
  end

  assign filt     = filt_r;
  assign rise_evt = settle_s & sync_s;
  assign fall_evt = settle_s & ~sync_s;

endmodule

// File: rtl/trigger_conditioner.sv
// Turns the raw target trigger pin into a single-cycle strobe fired on the Nth
// qualifying filtered edge after arming.
module trigger_conditioner
  import glitch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_W    = 8,
  parameter int COUNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                trigger_i,
  input  logic                arm_i,
  input  logic                disarm_i,
  input  logic [1:0]          edge_sel_i,
  input  logic [FILTER_W-1:0] filter_len_i,
  input  logic [COUNT_W-1:0]  edge_count_i,
  output logic                trigger_o,
  output logic                armed_o,
  output logic [COUNT_W-1:0]  edges_seen_o
);

  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t               state_r;
  state_t               state_nxt;
  logic [FILTER_W-1:0]  flen_r;
  logic [1:0]           sel_r;
  logic [COUNT_W-1:0]   target_r;
  logic [COUNT_W-1:0]   edges_r;
  logic [COUNT_W-1:0]   edges_nxt;
  logic [COUNT_W-1:0]   edges_inc_s;
  logic [COUNT_W-1:0]   target_s;
  logic                 trig_r;
  logic                 trig_nxt;
  logic                 armed_r;
  logic                 latch_s;
  logic                 qual_s;
  logic                 rise_s;
  logic                 fall_s;
  // Only the edge events are consumed here; the level itself is left for debug.
  logic                 filt_level_unused_s;

  trigger_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_W    (FILTER_W)
  ) u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .trigger_i (trigger_i),
    .flen      (flen_r),
    .filt      (filt_level_unused_s),
    .rise_evt  (rise_s),
    .fall_evt  (fall_s)
  );

  assign qual_s      = edge_qualifies(sel_r, rise_s, fall_s);
  assign edges_inc_s = (edges_r == {COUNT_W{1'b1}}) ? edges_r : (edges_r + CNT_ONE);
  assign target_s    = (edge_count_i == {COUNT_W{1'b0}}) ? CNT_ONE : edge_count_i;

  // Next-state: disarm beats both arm and a final edge.
  always_comb begin
    state_nxt = state_r;
    edges_nxt = edges_r;
    trig_nxt  = 1'b0;
    latch_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (arm_i && !disarm_i) begin
          latch_s   = 1'b1;
          edges_nxt = '0;
          state_nxt = ST_ARMED;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (disarm_i) begin
          state_nxt = ST_IDLE;
        end else if (qual_s) begin
          edges_nxt = edges_inc_s;
          if (edges_inc_s == target_r) begin
            trig_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_ARMED;
          end
        end else begin
          state_nxt = ST_ARMED;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      edges_r <= '0;
      trig_r  <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      state_r <= state_nxt;
      edges_r <= edges_nxt;
      trig_r  <= trig_nxt;
      armed_r <= (state_nxt == ST_ARMED);
    end
  end

  // Configuration is captured only on an accepted arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flen_r   <= '0;
      sel_r    <= EDGE_RISE;
      target_r <= '0;
    end else if (latch_s) begin
      flen_r   <= filter_len_i;
      sel_r    <= edge_sel_i;
      target_r <= target_s;
    end else begin
      flen_r   <= flen_r;
      sel_r    <= sel_r;
      target_r <= target_r;
    end
  end

  assign trigger_o    = trig_r;
  assign armed_o      = armed_r;
  assign edges_seen_o = edges_r;

endmodule

// File: tb/tb_trigger_conditioner.sv
// Self-checking bench for trigger_conditioner: vector table, directed corner
// sequences and randomized stimulus against a cycle-level behavioural model.
module tb_trigger_conditioner;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trigger_i;
  logic        arm_i;
  logic        disarm_i;
  logic [1:0]  edge_sel_i;
  logic [7:0]  filter_len_i;
  logic [15:0] edge_count_i;
  logic        trigger_o;
  logic        armed_o;
  logic [15:0] edges_seen_o;

  int checks = 0;
  int errors = 0;
  int trig_seen = 0;
  logic prev_trig = 1'b0;

  // Reference model state
  logic m_pipe[$];
  logic m_filt;
  int   m_run, m_flen, m_sel, m_target, m_edges;
  logic m_armed, m_trig;

  trigger_conditioner #(.SYNC_STAGES(S), .FILTER_W(8), .COUNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trigger_i    (trigger_i),
    .arm_i        (arm_i),
    .disarm_i     (disarm_i),
    .edge_sel_i   (edge_sel_i),
    .filter_len_i (filter_len_i),
    .edge_count_i (edge_count_i),
    .trigger_o    (trigger_o),
    .armed_o      (armed_o),
    .edges_seen_o (edges_seen_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        trig, arm, disarm;
    logic [1:0]  sel;
    logic [7:0]  flen;
    logic [15:0] cnt;
    logic        e_trig, e_armed;
    logic [15:0] e_edges;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < S; i++) m_pipe.push_back(1'b0);
    m_filt = 1'b0; m_run = 0; m_flen = 0; m_sel = 0; m_target = 0;
    m_edges = 0; m_armed = 1'b0; m_trig = 1'b0;
  endtask

  // Advances the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    logic s, evt, rise, fall, qual;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s    = m_pipe[0];
    evt  = (s != m_filt) && (m_run >= m_flen);
    rise = evt && s;
    fall = evt && !s;
    case (m_sel)
      1:       qual = fall;
      2:       qual = rise || fall;
      default: qual = rise;
    endcase
    m_trig = 1'b0;
    if (!m_armed) begin
      if (arm_i && !disarm_i) begin
        m_sel    = edge_sel_i;
        m_flen   = filter_len_i;
        m_target = (edge_count_i == 16'd0) ? 1 : edge_count_i;
        m_edges  = 0;
        m_armed  = 1'b1;
      end
    end else if (disarm_i) begin
      m_armed = 1'b0;
    end else if (qual) begin
      if (m_edges < 65535) m_edges++;
      if (m_edges == m_target) begin
        m_trig  = 1'b1;
        m_armed = 1'b0;
      end
    end
    if (evt) begin
      m_filt = s;
      m_run  = 0;
    end else if (s != m_filt) begin
      m_run++;
    end else begin
      m_run = 0;
    end
    void'(m_pipe.pop_front());
    m_pipe.push_back(trigger_i);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("trigger_o", trigger_o, m_trig);
    chk("armed_o", armed_o, m_armed);
    chk("edges_seen_o", edges_seen_o, m_edges);
    if (trigger_o) begin
      trig_seen++;
      chk("no_back_to_back", prev_trig, 1'b0);
    end
    prev_trig = trigger_o;
  endtask

  task automatic drive(input logic t, input logic a, input logic d, input logic [1:0] sel,
                       input logic [7:0] fl, input logic [15:0] cnt);
    trigger_i = t; arm_i = a; disarm_i = d;
    edge_sel_i = sel; filter_len_i = fl; edge_count_i = cnt;
  endtask

  task automatic arm_with(input logic [1:0] sel, input logic [7:0] fl, input logic [15:0] cnt);
    drive(trigger_i, 1'b1, 1'b0, sel, fl, cnt);
    step();
    arm_i = 1'b0;
  endtask

  task automatic hold(input logic t, input int n);
    trigger_i = t;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, first, exp_e[4];

    vecs[0] = '{1'b0, 1'b1, 1'b0, 2'b00, 8'd0, 16'd1, 1'b0, 1'b1, 16'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 16'd1, 1'b0, 1'b1, 16'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 16'd1, 1'b0, 1'b1, 16'd0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 16'd1, 1'b1, 1'b0, 16'd1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 16'd1, 1'b0, 1'b0, 16'd1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 16'd1, 1'b0, 1'b0, 16'd1};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 16'd0);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    chk("reset_trigger", trigger_o, 1'b0);
    chk("reset_armed", armed_o, 1'b0);
    chk("reset_edges", edges_seen_o, 16'd0);

    // Basic flen=0 rising trigger: strobe on the 3rd sampling edge.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].trig, vecs[i].arm, vecs[i].disarm, vecs[i].sel, vecs[i].flen, vecs[i].cnt);
      step();
      chk("vec_trigger", trigger_o, vecs[i].e_trig);
      chk("vec_armed", armed_o, vecs[i].e_armed);
      chk("vec_edges", edges_seen_o, vecs[i].e_edges);
    end
    hold(1'b0, 6);

    // flen=4: a 4-cycle pulse is rejected, a sustained level fires on edge 7.
    arm_with(2'b00, 8'd4, 16'd1);
    base = trig_seen;
    hold(1'b1, 4);
    hold(1'b0, 8);
    chk("short_pulse_no_trigger", trig_seen - base, 0);
    chk("short_pulse_edges", edges_seen_o, 16'd0);
    trigger_i = 1'b1;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (trigger_o && first == 0) first = k;
    end
    chk("flen4_latency", first, 7);
    hold(1'b0, 8);

    // Both edges, count 3.
    arm_with(2'b10, 8'd0, 16'd3);
    base = trig_seen;
    exp_e = '{1, 2, 3, 3};
    for (int ph = 0; ph < 4; ph++) begin
      hold((ph % 2) == 0, 10);
      chk("both_edges_count", edges_seen_o, exp_e[ph]);
    end
    chk("both_single_trigger", trig_seen - base, 1);

    // Count 0 behaves as 1; falling only.
    arm_with(2'b01, 8'd0, 16'd0);
    base = trig_seen;
    hold(1'b1, 10);
    chk("fall_ignores_rise", trig_seen - base, 0);
    hold(1'b0, 10);
    chk("fall_fires", trig_seen - base, 1);
    chk("fall_edges", edges_seen_o, 16'd1);

    // Disarm coinciding with the final qualifying edge.
    arm_with(2'b00, 8'd0, 16'd1);
    base = trig_seen;
    trigger_i = 1'b1;
    step();
    step();
    disarm_i = 1'b1;
    step();
    disarm_i = 1'b0;
    hold(1'b1, 3);
    chk("disarm_wins_trigger", trig_seen - base, 0);
    chk("disarm_wins_armed", armed_o, 1'b0);
    hold(1'b0, 4);
    arm_i = 1'b1; disarm_i = 1'b1;
    step();
    arm_i = 1'b0; disarm_i = 1'b0;
    chk("arm_disarm_same_cycle", armed_o, 1'b0);
    step();

    // Asynchronous reset while armed with two edges counted.
    arm_with(2'b10, 8'd0, 16'd5);
    hold(1'b1, 6);
    hold(1'b0, 6);
    chk("pre_reset_edges", edges_seen_o, 16'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_trigger", trigger_o, 1'b0);
    chk("async_reset_armed", armed_o, 1'b0);
    chk("async_reset_edges", edges_seen_o, 16'd0);
    model_reset();
    @(negedge clk);
    step();
    rst_n = 1'b1;
    base = trig_seen;
    hold(1'b1, 8);
    chk("no_trigger_after_reset", trig_seen - base, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) trigger_i = ~trigger_i;
      arm_i        = ($urandom_range(0, 15) == 0);
      disarm_i     = ($urandom_range(0, 40) == 0);
      edge_sel_i   = 2'($urandom_range(0, 3));
      filter_len_i = 8'($urandom_range(0, 6));
      edge_count_i = 16'($urandom_range(0, 4));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
